// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the radix-4 Booth multiplier.
// Holds the FSM state enum, the Booth digit enum and the iteration count function.
// ALIGN is present only when MUL_EARLY_OUT_EN is defined.
package mul_pkg;
  typedef enum logic [1:0] {
    IDLE,
    RUN
`ifdef MUL_EARLY_OUT_EN
    , ALIGN
`endif
  } state_t;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;
  function automatic int n_iter(int b_w);
    return (b_w + 2) / 2;
  endfunction
endpackage

// File: rtl/booth4_enc.sv
// booth4_enc: combinational radix-4 Booth recoder.
// Ports: bits = {b[i+1], b[i], look-back bit}; d = digit in {0, +-A, +-2A}.
module booth4_enc
  import mul_pkg::*;
(
  input  logic [2:0] bits,
  output digit_t     d
);
  assign d = (bits == 3'b011) ? POS2 :
             (bits == 3'b100) ? NEG2 :
             (bits == 3'b001 || bits == 3'b010) ? POS1 :
             (bits == 3'b101 || bits == 3'b110) ? NEG1 : ZERO;
endmodule

// File: rtl/mul_booth4.sv
// mul_booth4: sequential radix-4 Booth multiplier, one digit per clock.
// Ports: clk, rst_n (async active-low); a/b operands with a_signed/b_signed;
// stb starts an operation from IDLE, kill aborts; busy while in flight;
// ack pulses one cycle when o holds the product.
// Optional feature MUL_EARLY_OUT_EN: skip trailing all-zero/all-one multiplier
// digits with a single ALIGN shift.
module mul_booth4
  import mul_pkg::*;
#(
  parameter int A_W = 32,
  parameter int B_W = 32,
  parameter int O_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           a_signed,
  input  logic           b_signed,
  input  logic           stb,
  input  logic           kill,
  output logic           busy,
  output logic           ack,
  output logic [O_W-1:0] o
);
  localparam int AC_W = A_W + 3;
  localparam int R_W  = AC_W + B_W + 3;
  localparam int N    = n_iter(B_W);
  localparam int C_W  = $clog2(N + 1);
  state_t          state;
  digit_t          d;
  logic [R_W-1:0]  r, step;
  logic [A_W:0]    a_q;
  logic [C_W-1:0]  cnt;
  logic [AC_W-1:0] p1, p2, add, sum;
  logic            acc, last, eo;
  // r = {accumulator, multiplier (B_W+2 bits), look-back bit}
  booth4_enc u_enc (.bits(r[2:0]), .d(d));
  assign p1 = {{2{a_q[A_W]}}, a_q};
  assign p2 = {a_q[A_W], a_q, 1'b0};
  always_comb add = (d == POS1) ? p1 : (d == POS2) ? p2 : (d == NEG1) ? -p1 : (d == NEG2) ? -p2 : '0;
  assign sum  = r[R_W-1 -: AC_W] + add;
  assign step = $signed({sum, r[R_W-AC_W-1:0]}) >>> 2;
  assign last = cnt == C_W'(1);
  assign acc  = state == IDLE && stb && !kill;
  assign busy = state != IDLE;
  assign o    = r[O_W:1];
`ifdef MUL_EARLY_OUT_EN
  logic [B_W+2:0] low, msk;
  logic [R_W-1:0] align;
  // unretired multiplier bits sit in r[2*cnt:0]; uniform bits recode to all-zero digits
  assign low   = r[B_W+2:0];
  assign msk   = ~({(B_W+3){1'b1}} << {cnt, 1'b1});
  assign eo    = ((low & msk) == '0) || ((low | ~msk) == '1);
  assign align = $signed(r) >>> {cnt, 1'b0};
`else
  assign eo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (kill) state <= IDLE;
      else
        case (state)
          IDLE: if (stb) state <= RUN;
          RUN:
`ifdef MUL_EARLY_OUT_EN
            if (eo) state <= ALIGN;
            else
`endif
            if (last) begin
              state <= IDLE;
              ack   <= 1'b1;
            end
`ifdef MUL_EARLY_OUT_EN
          ALIGN: begin
            state <= IDLE;
            ack   <= 1'b1;
          end
`endif
          default: state <= IDLE;
        endcase
    end
  always_ff @(posedge clk)
    if (acc) begin
      a_q <= {a_signed & a[A_W-1], a};
      r   <= {{AC_W{1'b0}}, {2{b_signed & b[B_W-1]}}, b, 1'b0};
      cnt <= C_W'(N);
    end else if (state == RUN && !eo) begin
      r   <= step;
      cnt <= cnt - C_W'(1);
    end
`ifdef MUL_EARLY_OUT_EN
    else if (state == ALIGN) r <= align;
`endif
endmodule

// File: tb/tb_mul_booth4.sv
// tb_mul_booth4: directed scoreboard bench for mul_booth4 (A_W=B_W=32).
module tb_mul_booth4;
  logic        clk = 1'b0, rst_n, a_signed, b_signed, stb, kill, busy, ack;
  logic [31:0] a, b;
  logic [63:0] o, dummy;
  logic [63:0] sb[$];
  int          checks = 0, errors = 0, n;
  mul_booth4 dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
                  .stb(stb), .kill(kill), .busy(busy), .ack(ack), .o(o));
  always #5 clk = ~clk;
`ifdef MUL_EARLY_OUT_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 17;
`endif
  function automatic logic [63:0] model(logic [31:0] x, logic [31:0] y, logic xs, logic ys);
    logic signed [65:0] ex, ey, p;
    ex = xs ? {{34{x[31]}}, x} : {34'b0, x};
    ey = ys ? {{34{y[31]}}, y} : {34'b0, y};
    p  = ex * ey;
    return p[63:0];
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [31:0] x, input logic [31:0] y, input logic xs, input logic ys);
    a = x; b = y; a_signed = xs; b_signed = ys; stb = 1'b1;
    sb.push_back(model(x, y, xs, ys));
    @(posedge clk);
    #1 stb = 1'b0;
    a = $urandom; b = $urandom; a_signed = ~xs; b_signed = ~ys;
    check("busy_after_accept", {63'b0, busy}, 64'd1);
  endtask
  task automatic wait_ack(input string tag, input int lat);
    int cyc;
    logic [63:0] e;
    cyc = 0;
    e = sb.pop_front();
    while (!ack && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (!ack) check({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      check(tag, o, e);
      if (lat > 0) check({tag, "_latency"}, 64'(cyc), 64'(lat));
    end
  endtask
  task automatic count_acks(input int cycles);
    n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1 n += int'(ack);
    end
  endtask
  initial begin
    rst_n = 1'b0; stb = 1'b0; kill = 1'b0; a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_ack", {63'b0, ack}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    wait_ack("mulhu_max", 17);
    check("mulhu_max_const", o, 64'hFFFFFFFE00000001);
    @(posedge clk);
    #1 check("ack_one_cycle", {63'b0, ack}, 64'd0);
    check("idle_busy", {63'b0, busy}, 64'd0);
    check("o_held", o, 64'hFFFFFFFE00000001);
    go(32'h80000000, 32'h80000000, 1'b1, 1'b1);
    wait_ack("mul_minneg", 0);
    check("mul_minneg_const", o, 64'h4000000000000000);
    go(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    wait_ack("mul_m1", 0);
    check("mul_m1_const", o, 64'd1);
    go(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    wait_ack("mulhsu", 0);
    check("mulhsu_const", o, 64'hFFFFFFFF00000001);
    go(32'h00001234, 32'h0, 1'b0, 1'b0);
    wait_ack("b_zero", ZLAT);
    go(32'h3, 32'h5, 1'b0, 1'b0);
    wait_ack("small", 0);
    check("small_const", o, 64'hF);
    go(32'h7FFFFFFF, 32'h80000001, 1'b0, 1'b1);
    wait_ack("back_to_back", 0);
    go(32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_busy", {63'b0, busy}, 64'd0);
    check("kill_ack", {63'b0, ack}, 64'd0);
    dummy = sb.pop_back();
    go(32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 1'b0);
    wait_ack("after_kill", 17);
    go(32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_ack", {63'b0, ack}, 64'd0);
    dummy = sb.pop_back();
    @(negedge clk);
    rst_n = 1'b1;
    count_acks(25);
    check("rst_no_ack", 64'(n), 64'd0);
    @(negedge clk);
    go(32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0);
    a = 32'h11111111; b = 32'h22222222; stb = 1'b1;
    repeat (3) @(posedge clk);
    #1 stb = 1'b0;
    wait_ack("stb_ignored", 0);
    count_acks(25);
    check("single_ack", 64'(n), 64'd0);
    check("idle_after_ignored", {63'b0, busy}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      go($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_ack("random", 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_booth4.md
MUL_BOOTH4 -- requirements
Module: mul_booth4

Interface
REQ-001 Parameter A_W, default 32, multiplicand width; SHALL be >= 2.
REQ-002 Parameter B_W, default 32, multiplier width; SHALL be even and >= 2.
REQ-003 Parameter O_W, default A_W+B_W, product width; o SHALL carry product bits [O_W-1:0].
REQ-004 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- a  in  A_W  multiplicand.
- b  in  B_W  multiplier.
- a_signed  in  1  a is two's complement.
- b_signed  in  1  b is two's complement.
- stb  in  1  start request.
- kill  in  1  abort current operation.
- busy  out  1  operation in flight; stb is ignored.
- ack  out  1  one-cycle pulse; o is valid.
- o  out  O_W  product.

Function
REQ-005 States SHALL be IDLE, RUN and ALIGN; ALIGN SHALL exist only with MUL_EARLY_OUT_EN.
REQ-006 In IDLE with stb=1 and kill=0, a clock edge T SHALL perform all of the following.
- Capture a, a_signed and b_signed.
- Load the multiplier as b extended by 2 bits (sign-extended if b_signed, else zero-extended), plus a Booth look-back bit of 0.
- Clear the accumulator and enter RUN.
REQ-007 Each RUN edge SHALL retire one radix-4 Booth digit from 3 multiplier bits: 0, ±A or ±2A.
- A is a extended by one bit (sign if a_signed, else zero).
- The digit SHALL be added into an accumulator A_W+3 bits wide.
- The accumulator-plus-multiplier register SHALL then shift arithmetically right by 2.
REQ-008 The iteration count SHALL be N=(B_W+2)/2; N=17 for B_W=32.
REQ-009 Without early-out, the edge performing iteration N (edge T+N) SHALL return to IDLE and set ack=1 for exactly one cycle.
REQ-010 busy SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-011 o SHALL hold the low O_W bits of the final product from the ack cycle until the next accepted stb; otherwise o is don't-care.
REQ-012 stb while busy=1 SHALL be ignored, with no queueing.
REQ-013 stb in the cycle ack=1 SHALL be accepted, because the state is already IDLE.
REQ-014 kill=1 in any state SHALL force IDLE at the next edge, with no ack; kill and stb together in IDLE SHALL drop the stb.
REQ-015 a and b SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the result.
REQ-016 Any a_signed/b_signed combination SHALL give the exact product, covering MUL, MULH, MULHSU and MULHU.

Reset
REQ-017 rst_n=0 SHALL asynchronously force IDLE, busy=0 and ack=0.
REQ-018 Reset mid-operation SHALL discard the operation with no ack.
REQ-019 Datapath registers and o SHALL NOT be reset.

Configuration
REQ-020 With MUL_EARLY_OUT_EN defined, RUN SHALL test the unretired multiplier bits plus the look-back bit before each iteration.
- If they are all 0 or all 1, the state SHALL move to ALIGN instead of iterating.
- The ALIGN edge SHALL arithmetic-shift the register right by 2 times the remaining digit count, return to IDLE and pulse ack.
REQ-021 Without MUL_EARLY_OUT_EN, latency SHALL be fixed at N edges and no ALIGN logic or shifter SHALL be synthesised.

Structure
REQ-022 Package mul_pkg SHALL hold the state enum, the Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2) and a function for N.
REQ-023 Sub-module booth4_enc SHALL map 3 multiplier bits to a digit combinationally.

Verification (A_W=B_W=32; stb accepted at edge T)
REQ-024 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> o=0xFFFFFFFE00000001; ack at edge T+17 without early-out.
REQ-025 Signed 0x80000000*0x80000000 -> o=0x4000000000000000; signed 0xFFFFFFFF*0xFFFFFFFF -> o=1.
REQ-026 a_signed=1, b_signed=0, a=0xFFFFFFFF, b=0xFFFFFFFF -> o=0xFFFFFFFF00000001.
REQ-027 Early-out: b=0, a=0x1234 -> o=0 with ack at T+2 when MUL_EARLY_OUT_EN is defined, at T+17 when not; b=0x5, a=0x3 -> o=0xF.
REQ-028 kill at edge T+5 -> no ack, busy=0 after T+5; a new stb at T+6 -> correct ack at T+23.
REQ-029 rst_n low at T+8 -> busy=0 and ack=0 immediately; stb during busy -> ignored, with a single ack for the first operation only.
